// File: rtl/audio_adc_i2s_rx.sv
// audio_adc_i2s_rx
// I2S receiver for a stereo audio ADC. bclk, adclrck and adcdat are
// synchronized into the clk domain (clk must run at least 4x bclk). Each
// channel word is shifted in MSB-first after the I2S one-bit delay. The left
// word is held until the right word ends, then both are committed together
// with a one-clk sample_valid pulse.
// Optional feature: define AUDIO_ADC_SIGN_EXTEND_EN to sign-extend
// bits [31:DATA_WIDTH] of both outputs; otherwise those bits are zero.
module audio_adc_i2s_rx #(
   parameter int DATA_WIDTH = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        bclk,
   input  logic        adclrck,
   input  logic        adcdat,
   output logic [31:0] left_data,
   output logic [31:0] right_data,
   output logic        sample_valid,
   output logic        short_word
);

   localparam logic [5:0] LP_WIDTH = 6'(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALIGN = 3'd1,
      DELAY = 3'd2,
      SHIFT = 3'd3,
      HOLD  = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;

   logic [1:0]              r_bclk_sync;
   logic [1:0]              r_lrck_sync;
   logic [1:0]              r_dat_sync;
   logic                    r_bclk_prev;
   logic                    r_lrck_prev;

   logic [DATA_WIDTH-1:0]   r_shift;
   logic [5:0]              r_cnt;
   logic [DATA_WIDTH-1:0]   r_left_word;
   logic [DATA_WIDTH-1:0]   r_left_out;
   logic [DATA_WIDTH-1:0]   r_right_out;
   logic                    r_valid;
   logic                    r_short;

   logic                    w_lrck;
   logic                    w_dat;
   logic                    w_bclk_rise;
   logic                    w_lrck_edge;
   logic                    w_left_start;
   logic [DATA_WIDTH-1:0]   w_shift_next;
   logic [5:0]              w_cnt_next;
   logic [5:0]              w_pad;
   logic                    w_full;
   logic [DATA_WIDTH-1:0]   w_word;

   logic                    w_capture;
   logic                    w_clear;
   logic                    w_word_end;
   logic                    w_word_short;
   logic                    w_store_left;
   logic                    w_commit;

   // Fill bits [31:DATA_WIDTH] of an output word.
   function automatic logic [31:0] extend_word(input logic [DATA_WIDTH-1:0] word);
`ifdef AUDIO_ADC_SIGN_EXTEND_EN
      extend_word = 32'($signed(word));
`else
      extend_word = 32'(word);
`endif
   endfunction

   assign w_lrck       = r_lrck_sync[1];
   assign w_dat        = r_dat_sync[1];
   assign w_bclk_rise  = r_bclk_sync[1] & ~r_bclk_prev;
   // adclrck is only looked at on bclk rising edges, so an edge is a change
   // relative to the level sampled at the previous rising edge.
   assign w_lrck_edge  = w_bclk_rise & (w_lrck != r_lrck_prev);
   assign w_left_start = w_bclk_rise & r_lrck_prev & ~w_lrck;

   // The bit on an adclrck-edge bclk still belongs to the channel that is
   // ending, so it is shifted in before deciding complete vs. short.
   assign w_shift_next = {r_shift[DATA_WIDTH-2:0], w_dat};
   assign w_cnt_next   = r_cnt + 6'd1;
   assign w_full       = (w_cnt_next == LP_WIDTH);
   assign w_pad        = LP_WIDTH - w_cnt_next;
   assign w_word       = w_full ? w_shift_next : (w_shift_next << w_pad);

   // Synchronize the codec pins and track last sampled bclk / adclrck levels.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bclk_sync <= 2'b00;
         r_lrck_sync <= 2'b00;
         r_dat_sync  <= 2'b00;
         r_bclk_prev <= 1'b0;
         r_lrck_prev <= 1'b0;
      end else begin
         r_bclk_sync <= {r_bclk_sync[0], bclk};
         r_lrck_sync <= {r_lrck_sync[0], adclrck};
         r_dat_sync  <= {r_dat_sync[0], adcdat};
         r_bclk_prev <= r_bclk_sync[1];
         if (w_bclk_rise) begin
            r_lrck_prev <= w_lrck;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic; dropping enable always returns to IDLE.
   always_comb begin
      w_state_next = r_state;
      if (!enable) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE:  w_state_next = ALIGN;
            ALIGN: if (w_left_start) w_state_next = DELAY;
            // The edge that revealed the new adclrck level is the skipped
            // delay bit, so the next bclk rise carries the MSB.
            DELAY: w_state_next = SHIFT;
            SHIFT: begin
               if (w_lrck_edge) begin
                  w_state_next = DELAY;
               end else if (w_bclk_rise && w_full) begin
                  w_state_next = HOLD;
               end
            end
            HOLD:  if (w_lrck_edge) w_state_next = DELAY;
            default: w_state_next = IDLE;
         endcase
      end
   end

   // FSM outputs: capture strobes and word-end events. The channel of the
   // ending word is the adclrck level sampled before the current edge.
   always_comb begin
      w_capture    = 1'b0;
      w_clear      = 1'b0;
      w_word_end   = 1'b0;
      w_word_short = 1'b0;
      w_store_left = 1'b0;
      w_commit     = 1'b0;
      if (enable) begin
         w_clear = (r_state != SHIFT);
         if (r_state == SHIFT && w_bclk_rise) begin
            w_capture    = 1'b1;
            w_word_end   = w_full | w_lrck_edge;
            w_word_short = w_lrck_edge & ~w_full;
         end
         w_store_left = w_word_end & ~r_lrck_prev;
         w_commit     = w_word_end & r_lrck_prev;
      end
   end

   // Shift register and bit count for the word in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift <= '0;
         r_cnt   <= 6'd0;
      end else if (w_clear) begin
         r_shift <= '0;
         r_cnt   <= 6'd0;
      end else if (w_capture) begin
         r_shift <= w_shift_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Hold the left word, commit the stereo pair, track the short-word flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_left_word <= '0;
         r_left_out  <= '0;
         r_right_out <= '0;
         r_valid     <= 1'b0;
         r_short     <= 1'b0;
      end else begin
         r_valid <= w_commit;
         if (w_store_left) begin
            r_left_word <= w_word;
         end
         if (w_commit) begin
            r_left_out  <= r_left_word;
            r_right_out <= w_word;
         end
         if (w_word_short) begin
            r_short <= 1'b1;
         end
      end
   end

   assign left_data    = extend_word(r_left_out);
   assign right_data   = extend_word(r_right_out);
   assign sample_valid = r_valid;
   assign short_word   = r_short;

endmodule

// File: doc/audio_adc_i2s_rx.md
AUDIO_ADC_I2S_RX -- requirements
Module: audio_adc_i2s_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, giving the codec word length in bits; legal values are 16 to 32.
REQ-002 The block SHALL have the port clk, input, 1 bit, the system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have the port reset_n, input, 1 bit, an asynchronous, active-low reset.
REQ-004 The block SHALL have the port enable, input, 1 bit; capture runs only while it is high.
REQ-005 The block SHALL have the port bclk, input, 1 bit, the codec bit clock; it is asynchronous to clk.
REQ-006 The block SHALL have the port adclrck, input, 1 bit, the codec word select; low means left, high means right; it is asynchronous.
REQ-007 The block SHALL have the port adcdat, input, 1 bit, the codec serial data; it is asynchronous.
REQ-008 The block SHALL have the port left_data, output, 32 bits, the last committed left sample, right-justified.
REQ-009 The block SHALL have the port right_data, output, 32 bits, the last committed right sample, right-justified.
REQ-010 The block SHALL have the port sample_valid, output, 1 bit, a one-clk pulse marking each committed stereo pair.
REQ-011 The block SHALL have the port short_word, output, 1 bit, a sticky flag set when a channel ends before DATA_WIDTH bits have been captured.

Function
REQ-012 bclk, adclrck and adcdat SHALL each pass through a two-flop synchronizer into the clk domain; clk SHALL be at least 4x bclk.
REQ-013 A bclk rising edge SHALL be detected from the synchronized bclk; adclrck and adcdat SHALL be sampled only at detected bclk rising edges.
REQ-014 The FSM SHALL have the states IDLE, ALIGN, DELAY, SHIFT and HOLD.
REQ-015 IDLE: the block SHALL go to ALIGN when enable is high.
REQ-016 ALIGN: the block SHALL wait for a sampled adclrck high-to-low transition (start of left), then go to DELAY.
REQ-017 DELAY: the block SHALL skip exactly one bclk rising edge (I2S one-bit delay), then go to SHIFT with bit count 0.
REQ-018 SHIFT: the block SHALL shift adcdat in MSB-first, once per bclk rising edge, and increment the bit count.
REQ-019 SHIFT: when the bit count reaches DATA_WIDTH, the channel word SHALL be complete and the block SHALL go to HOLD.
REQ-020 HOLD: the block SHALL ignore further bits until the next adclrck transition, then go to DELAY for the other channel.
REQ-021 An adclrck transition seen in SHIFT SHALL end the channel early: the captured bits are left-aligned within DATA_WIDTH, the missing LSBs are zero, short_word is set, and the block goes to DELAY.
REQ-022 The left word SHALL be held internally until the right word ends, by completion or by an early adclrck edge.
REQ-023 When the right word ends, left_data and right_data SHALL update together, and sample_valid SHALL be high for exactly one clk, in the clk cycle after the detecting edge.
REQ-024 The latency from the bclk rising edge at the codec pin to sample_valid SHALL be at most 4 clk.
REQ-025 Each output word SHALL carry the sample in bits [DATA_WIDTH-1:0]; bits [31:DATA_WIDTH] are set by REQ-031/REQ-032.
REQ-026 If enable goes low, the FSM SHALL return to IDLE in the next clk, discard any partial word, and hold left_data, right_data and short_word.
REQ-027 If an adclrck transition coincides with the DATA_WIDTH-th bit, the word SHALL count as complete, without short_word.

Reset
REQ-028 While reset_n is low, all synchronizers, the shift register and the bit count SHALL clear, and the FSM SHALL be in IDLE.
REQ-029 While reset_n is low, left_data and right_data SHALL be 0, and sample_valid and short_word SHALL be 0.
REQ-030 A reset asserted mid-frame SHALL discard the frame; after release, capture SHALL restart at the next left-channel start.

Configuration
REQ-031 With macro AUDIO_ADC_SIGN_EXTEND_EN defined, bits [31:DATA_WIDTH] of both outputs SHALL copy bit DATA_WIDTH-1.
REQ-032 Without AUDIO_ADC_SIGN_EXTEND_EN, bits [31:DATA_WIDTH] of both outputs SHALL be 0.

Verification
REQ-033 Bench SHALL cover: DATA_WIDTH=24, 32-bit slots, left 0x123456, right 0xABCDEF -> left_data 0x00123456, right_data 0x00ABCDEF (macro off), one sample_valid pulse per frame.
REQ-034 Bench SHALL cover: same stimulus with the macro on -> right_data 0xFFABCDEF, left_data 0x00123456.
REQ-035 Bench SHALL cover: DATA_WIDTH=24, 16-bit slots, left 0xA5A5 -> left_data 0x00A5A500, short_word=1.
REQ-036 Bench SHALL cover: reset released mid right channel -> no sample_valid until a full left+right frame is received; the first pair is correct.
REQ-037 Bench SHALL cover: enable dropped mid-left, then raised -> outputs hold the old pair, and the next full frame commits correctly.
REQ-038 Bench SHALL cover: clk = 4x bclk and a 1000-frame random stream -> every pair matches the reference model, with no extra or missing sample_valid pulses.
